// File: rtl/result_qalign_collector_if.sv
// Handshake bundle for the result Q-align collector: element input stream and aligned output stream.
interface result_qalign_collector_if #(
  parameter int WORD_SIZE = 16,
  parameter int VEC_LEN   = 8,
  parameter int QW        = 4
);
  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_SIZE-1:0] in_data;
  logic [QW-1:0]        in_qi;
  logic [QW-1:0]        in_qf;

  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic [QW-1:0]        out_qi;
  logic [QW-1:0]        out_qf;
  logic [IW-1:0]        out_idx;
  logic                 out_last;
  logic                 out_fmt_err;

  // collector side
  modport slave (
    input  in_valid, in_data, in_qi, in_qf, out_ready,
    output in_ready, out_valid, out_data, out_qi, out_qf, out_idx, out_last, out_fmt_err
  );

  // producer / consumer side
  modport master (
    output in_valid, in_data, in_qi, in_qf, out_ready,
    input  in_ready, out_valid, out_data, out_qi, out_qf, out_idx, out_last, out_fmt_err
  );
endinterface

// File: rtl/result_qalign_collector.sv
// Buffers one vector of Q-tagged elements, aligns all to the smallest QF, then streams them out
// with a single common QI/QF per vector.
module result_qalign_collector #(
  parameter int WORD_SIZE = 16,
  parameter int VEC_LEN   = 8,
  parameter int QW        = 4
) (
  input  logic                      src_clk,
  input  logic                      rst_n,
  result_qalign_collector_if.slave  bus
);
  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  typedef enum logic [1:0] {S_COLLECT, S_ALIGN, S_DRAIN} state_t;

  state_t r_state, w_next;

  logic [WORD_SIZE-1:0] r_buf [VEC_LEN];
  logic [QW-1:0]        r_qf  [VEC_LEN];
  logic [IW-1:0]        r_count;
  logic [QW-1:0]        r_min_qf;
  logic                 r_err;

  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_data;
  logic [QW-1:0]        r_out_qi;
  logic [QW-1:0]        r_out_qf;
  logic [IW-1:0]        r_out_idx;
  logic                 r_out_last;
  logic                 r_out_fmt_err;

  logic                        w_in_ready;
  logic                        w_in_fire;
  logic                        w_in_last;
  logic                        w_out_fire;
  logic                        w_load;
  logic [IW-1:0]               w_sel;
  logic [QW-1:0]               w_sh;
  logic signed [WORD_SIZE-1:0] w_buf_sel;
  logic signed [WORD_SIZE-1:0] w_aligned;
  logic [QW:0]                 w_qsum;
  logic                        w_bad;

  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_in_last  = (r_count == IW'(VEC_LEN - 1));
  assign w_out_fire = r_out_valid & bus.out_ready;

  // Format check is done one bit wider so qi+qf cannot wrap back onto WORD_SIZE.
  assign w_qsum = {1'b0, bus.in_qi} + {1'b0, bus.in_qf};
  assign w_bad  = (w_qsum != (QW+1)'(WORD_SIZE));

  // Element 0 loads on the first DRAIN cycle; afterwards each accepted non-last element advances.
  assign w_load    = (r_state == S_DRAIN) && (!r_out_valid || (w_out_fire && !r_out_last));
  assign w_sel     = r_out_valid ? (r_out_idx + IW'(1)) : '0;
  assign w_sh      = r_qf[w_sel] - r_min_qf;
  assign w_buf_sel = r_buf[w_sel];
  assign w_aligned = w_buf_sel >>> w_sh;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_COLLECT: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_in_last) w_next = S_ALIGN;
      end
      S_ALIGN:   w_next = S_DRAIN;
      S_DRAIN:   if (w_out_fire && r_out_last) w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge src_clk) begin
    if (w_in_fire) begin
      r_buf[r_count] <= bus.in_data;
      r_qf[r_count]  <= bus.in_qf;
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_min_qf      <= '1;
      r_err         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_qi      <= '0;
      r_out_qf      <= '0;
      r_out_idx     <= '0;
      r_out_last    <= 1'b0;
      r_out_fmt_err <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_count  <= r_count + IW'(1);
        r_min_qf <= (bus.in_qf < r_min_qf) ? bus.in_qf : r_min_qf;
        r_err    <= r_err | w_bad;
      end
      if (r_state == S_ALIGN) begin
        r_out_qf      <= r_min_qf;
        r_out_qi      <= QW'(WORD_SIZE) - r_min_qf;
        r_out_fmt_err <= r_err;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_aligned;
        r_out_idx   <= w_sel;
        r_out_last  <= (w_sel == IW'(VEC_LEN - 1));
      end else if (w_out_fire && r_out_last) begin
        r_out_valid <= 1'b0;
        r_count     <= '0;
        r_min_qf    <= '1;
        r_err       <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_qi      = r_out_qi;
  assign bus.out_qf      = r_out_qf;
  assign bus.out_idx     = r_out_idx;
  assign bus.out_last    = r_out_last;
  assign bus.out_fmt_err = r_out_fmt_err;
endmodule
